// File: rtl/ftoi_conv_if.sv
// Operand/result bundle for the binary32 -> int32 converter.
// The producer drives in_valid/x; the converter returns out_valid/y/exception one cycle later.
interface ftoi_conv_if;
    logic        in_valid;
    logic [31:0] x;
    logic        out_valid;
    logic [31:0] y;
    logic        exception;

    modport master (
        output in_valid,
        output x,
        input  out_valid,
        input  y,
        input  exception
    );

    modport slave (
        input  in_valid,
        input  x,
        output out_valid,
        output y,
        output exception
    );
endinterface

// File: rtl/ftoi_conv.sv
// Single-cycle registered IEEE-754 binary32 to int32 conversion.
// Rounds to nearest with ties away from zero, and saturates with an exception flag on overflow, Inf and NaN.
module ftoi_conv (
    input  logic        clk,
    input  logic        rst,
    ftoi_conv_if.slave  bus_io
);

    typedef enum logic [1:0] {
        CLS_ROUND    = 2'd0,
        CLS_LSHIFT   = 2'd1,
        CLS_MIN_INT  = 2'd2,
        CLS_OVERFLOW = 2'd3
    } cls_e;

    localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    logic        sgn;
    logic [7:0]  expo;
    logic [22:0] man;
    logic [23:0] sig;
    cls_e        cls;
    logic [7:0]  rsh;
    logic [2:0]  lsh;
    logic [23:0] twice;
    logic [31:0] mag;
    logic        is_nan;
    logic [31:0] y_d;
    logic        exc_d;
    logic        out_valid_q;
    logic [31:0] y_q;
    logic        exc_q;

    assign sgn    = bus_io.x[31];
    assign expo   = bus_io.x[30:23];
    assign man    = bus_io.x[22:0];
    assign sig    = {expo != 8'd0, man};
    assign is_nan = (expo == 8'hFF) && (man != 23'd0);

    // Below exponent 150 the value carries fraction bits; shifting so that one
    // fraction bit survives yields twice the truncated magnitude plus the round bit.
    assign rsh   = 8'd149 - expo;
    assign lsh   = 3'(expo - 8'd150);
    assign twice = sig >> rsh;

    // NOTE: every output of an always_comb block gets a default first, so no
    // path through the case/if tree can leave a value unassigned and infer a latch.
    always_comb begin
        cls   = CLS_ROUND;
        mag   = 32'd0;
        y_d   = 32'd0;
        exc_d = 1'b0;

        if (expo >= 8'd159) begin
            cls = CLS_OVERFLOW;
        end else if (expo == 8'd158) begin
            cls = (bus_io.x == 32'hCF00_0000) ? CLS_MIN_INT : CLS_OVERFLOW;
        end else if (expo >= 8'd150) begin
            cls = CLS_LSHIFT;
        end

        case (cls)
            CLS_ROUND:  mag = 32'(({1'b0, twice} + 25'd1) >> 1);
            CLS_LSHIFT: mag = {8'd0, sig} << lsh;
            default:    mag = 32'd0;
        endcase

        case (cls)
            CLS_ROUND, CLS_LSHIFT: y_d = sgn ? (32'd0 - mag) : mag;
            CLS_MIN_INT:           y_d = INT_MIN;
            default: begin
                y_d   = (sgn && !is_nan) ? INT_MIN : INT_MAX;
                exc_d = 1'b1;
            end
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of the order the simulator evaluates blocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            y_q         <= 32'd0;
            exc_q       <= 1'b0;
        end else begin
            out_valid_q <= bus_io.in_valid;
            if (bus_io.in_valid) begin
                y_q   <= y_d;
                exc_q <= exc_d;
            end
        end
    end

    assign bus_io.out_valid = out_valid_q;
    assign bus_io.y         = y_q;
    assign bus_io.exception = exc_q;

endmodule

// File: tb/tb_ftoi_conv.sv
// Randomised scoreboard bench for ftoi_conv: a real-arithmetic reference model
// predicts each result, and an independent monitor checks whatever the DUT emits.
module tb_ftoi_conv;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    ftoi_conv_if bus ();

    ftoi_conv dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic        exc;
    } exp_t;

    exp_t exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Exact value of a finite binary32 as a real (double holds it exactly).
    function automatic real mag_of(input logic [31:0] v);
        int  e;
        int  p;
        real r;
        e = int'(v[30:23]);
        if (e == 0) begin
            r = real'(v[22:0]);
            p = -149;
        end else begin
            r = real'({1'b1, v[22:0]});
            p = e - 150;
        end
        for (int i = 0; i < p; i++) r = r * 2.0;
        for (int i = 0; i > p; i--) r = r / 2.0;
        return r;
    endfunction

    function automatic exp_t model(input logic [31:0] v);
        exp_t   t;
        real    r;
        longint n;
        logic   neg;
        t.x   = v;
        neg   = v[31];
        t.exc = 1'b0;
        if (v[30:23] == 8'hFF) begin
            t.exc = 1'b1;
            t.y   = (neg && v[22:0] == 23'd0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            r = mag_of(v);
            if (!neg && r >= 2147483648.0) begin
                t.exc = 1'b1;
                t.y   = 32'h7FFF_FFFF;
            end else if (neg && r > 2147483648.0) begin
                t.exc = 1'b1;
                t.y   = 32'h8000_0000;
            end else begin
                n   = longint'($rtoi($floor(r + 0.5)));
                t.y = 32'(neg ? -n : n);
            end
        end
        return t;
    endfunction

    task automatic send(input logic [31:0] v);
        bus.in_valid = 1'b1;
        bus.x        = v;
        exp_q.push_back(model(v));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.x        = $urandom;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: out_valid must follow (in_valid && !rst) one edge late; results are
    // popped from the scoreboard, and outputs must hold while out_valid is low.
    logic        exp_ov;
    logic        rst_seen;
    logic [31:0] last_y;
    logic        last_exc;

    always @(posedge clk) begin
        exp_ov   <= bus.in_valid && !rst;
        rst_seen <= rst;
    end

    always @(negedge clk) begin
        exp_t t;
        if (rst_seen !== 1'bx) begin
            check("out_valid", 32'(bus.out_valid), 32'(exp_ov));
            if (rst_seen) begin
                last_y   = 32'd0;
                last_exc = 1'b0;
            end
            if (bus.out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'd1, 32'd0);
                end else begin
                    t = exp_q.pop_front();
                    if (bus.y !== t.y)
                        $display("  operand %h", t.x);
                    check("y", bus.y, t.y);
                    check("exception", 32'(bus.exception), 32'(t.exc));
                    last_y   = t.y;
                    last_exc = t.exc;
                end
            end else begin
                check("y_hold", bus.y, last_y);
                check("exception_hold", 32'(bus.exception), 32'(last_exc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [22:0] MAN_PAT [7] = '{23'h0, 23'h1, 23'h2, 23'h380000,
                                            23'h400000, 23'h5FFFFF, 23'h7FFFFF};
    localparam logic [31:0] DIRECTED [23] = '{
        32'h3F80_0000, 32'h4020_0000, 32'hC020_0000, 32'h3F00_0000, 32'h3EFF_FFFF,
        32'h3FC0_0000, 32'h0000_0000, 32'h8000_0000, 32'h0000_0001, 32'h3E80_0000,
        32'h4EFF_FFFF, 32'hCF00_0000, 32'h4F00_0000, 32'hCF00_0001, 32'h7F80_0000,
        32'hFF80_0000, 32'h7FC0_0000, 32'hFFC0_0001, 32'hBF00_0000, 32'hCEFF_FFFF,
        32'h4B7F_FFFF, 32'hCB00_0001, 32'h4AFF_FFFF
    };

    initial begin
        logic [31:0] v;
        total        = 0;
        bad          = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.x        = 32'h3F80_0000;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(3);

        // Spot values with hand-known answers, so a wrong model cannot hide a wrong DUT.
        send(32'h4020_0000);
        send(32'hC020_0000);
        idle(1);
        check("y_2p5", last_y, 32'hFFFF_FFFD);
        send(32'h4EFF_FFFF);
        idle(1);
        check("y_max_finite", last_y, 32'h7FFF_FF80);

        foreach (DIRECTED[i]) send(DIRECTED[i]);
        idle(2);

        for (int s = 0; s < 2; s++) begin
            for (int e = 0; e < 255; e++) begin
                foreach (MAN_PAT[k]) send({s[0], e[7:0], MAN_PAT[k]});
                repeat (2) send({s[0], e[7:0], 23'($urandom)});
            end
        end
        idle(1);

        for (int i = 0; i < 300; i++) begin
            v = $urandom;
            if ($urandom_range(3) == 0) idle(1);
            send(v);
        end
        idle(4);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ftoi_conv.md
Name: ftoi_conv

Overview:
Converts an IEEE-754 binary32 value to a signed 32-bit two's-complement integer. Rounding is to nearest, ties away from zero, matching the SystemVerilog shortreal-to-int conversion. It is a single-cycle registered stage inside the FPU datapath, and it flags inputs that cannot be represented as an int32.

Parameters:
None.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  x is valid this cycle
x  input  32  binary32 operand: sign x[31], exponent x[30:23], mantissa x[22:0]
out_valid  output  1  y and exception are valid; equals in_valid delayed by one cycle
y  output  32  signed int32 result
exception  output  1  input is out of int32 range, or is Inf/NaN

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: on a clk edge with rst=1, out_valid=0, y=0 and exception=0. Reset overrides in_valid. An operand presented in the same cycle as reset is discarded.
- Latency: exactly 1 cycle, no stalls, one result per cycle.
  - Combinational conversion of x is registered every edge when in_valid=1.
  - When in_valid=0, y and exception hold their previous values and out_valid=0.
- Decode: s = x[31], e = x[30:23], m = x[22:0], significand M = {1, m} (24 bits).
- Zero and denormal inputs (e=0): y=0, exception=0. This includes -0.
- e <= 125 (|x| < 0.5): y=0, exception=0.
- e = 126 (0.5 <= |x| < 1): magnitude rounds to 1, including exactly 0.5. y = s ? -1 : 1.
- 127 <= e <= 157:
  - Integer part: M shifted so the binary point sits at bit (e-127).
  - Round bit: the first fraction bit. Any round bit of 1 increments the magnitude (ties away from zero). Sticky bits are ignored.
  - For e >= 150 there are no fraction bits: M is shifted left by (e-150) and no rounding is applied.
  - Magnitude stays below 2^31; the result is two's-complement negated when s=1.
- e = 158:
  - x = 0xCF000000 (exactly -2^31): y = 0x80000000, exception=0.
  - Any other value: overflow.
- e >= 159 and e <= 254: overflow.
- e = 255 (Inf or NaN): overflow.
- Overflow handling, exception=1:
  - s=0: y = 0x7FFFFFFF.
  - s=1 and m=0 with e<255: y = 0x80000000.
  - NaN (e=255, m!=0), either sign: y = 0x7FFFFFFF.
  - -Inf: y = 0x80000000.
- Exception condition: exception=1 exactly when x >= 2^31, x < -2^31, or e=255.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with in_valid=1 and x=0x3F800000 -> out_valid=0, y=0, exception=0. After rst falls, that operand is not output.
- Basic and ties: 0x3F800000 -> 1; 0x40200000 (2.5) -> 3; 0xC0200000 (-2.5) -> -3; 0x3F000000 (0.5) -> 1; 0x3EFFFFFF -> 0; 0x3FC00000 (1.5) -> 2. All with exception=0 and 1-cycle latency.
- Small values: 0x00000000, 0x80000000, 0x00000001 and 0x3E800000 -> y=0, exception=0.
- Upper range: 0x4EFFFFFF -> 0x7FFFFF80, exception=0. 0xCF000000 -> 0x80000000, exception=0. 0x4F000000 -> 0x7FFFFFFF, exception=1. 0xCF000001 -> 0x80000000, exception=1.
- Specials: 0x7F800000 -> 0x7FFFFFFF with exception=1. 0xFF800000 -> 0x80000000 with exception=1. 0x7FC00000 and 0xFFC00001 -> 0x7FFFFFFF with exception=1.
- Sweep:
  - Stimulus: every exponent 0..254 and both signs, with mantissa patterns 0, 1, 2, 0x380000, 0x400000, 0x5FFFFF, 0x7FFFFF, plus random mantissas.
  - Back-to-back in_valid=1 every cycle.
  - Required response: y equals the round-half-away-from-zero int of x for each in-range input, and out_valid tracks in_valid with one-cycle delay.
